// File: rtl/banked_mem_unit.sv
// Byte-banked big-endian data memory: 1..LANES byte loads/stores at any address, sign/zero-extended loads.
// Load/fault response one cycle after acceptance; req_ready low only during the post-reset clear.
module banked_mem_unit #(
  parameter int LANES            = 4,
  parameter int ADDR_WIDTH       = 18,
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter bit CLEAR_ON_RESET   = 1'b1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_store,
  input  logic [2:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [8*LANES-1:0]      req_wdata,
  output logic                    rsp_valid,
  output logic [8*LANES-1:0]      rsp_rdata,
  output logic                    rsp_error
);
  localparam int OFFW  = $clog2(LANES);
  localparam int ROWW  = ADDR_WIDTH - OFFW;
  localparam int DEPTH = 1 << ROWW;
  localparam logic [ROWW-1:0] LAST_ROW = '1;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t          state, state_nxt;
  logic [ROWW-1:0] cnt, cnt_nxt;
  logic            clearing;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clearing  = 1'b0;
    case (state)
      S_CLEAR: begin
        clearing = 1'b1;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == LAST_ROW) state_nxt = S_READY;
      end
      default: ;
    endcase
  end

  // req_ready is registered off the next state so it stays low for the reset edge itself
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      cnt       <= '0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_ready <= (state_nxt == S_READY);
    end
  end

  logic                  accept, fault, misaligned;
  logic [OFFW-1:0]       off;
  logic [ROWW-1:0]       row;
  int                    nbytes;

  assign accept     = req_valid && req_ready && !reset;
  assign off        = req_addr[OFFW-1:0];
  assign row        = req_addr[ADDR_WIDTH-1:OFFW];
  assign nbytes     = 32'd1 << req_size;
  assign misaligned = (req_addr & ~({ADDR_WIDTH{1'b1}} << req_size)) != '0;
  assign fault      = (req_size > 3'(OFFW)) || (!ALLOW_MISALIGNED && misaligned);

  logic [OFFW-1:0] lane_idx [LANES];
  logic [ROWW-1:0] bank_row [LANES];
  logic            bank_we  [LANES];
  logic [7:0]      bank_wd  [LANES];
  logic [7:0]      bank_rd  [LANES];

  // lane_idx is the position of this bank's byte within the access (0 = most significant)
  always_comb begin
    for (int b = 0; b < LANES; b++) begin
      lane_idx[b] = OFFW'(b) - off;
      bank_row[b] = clearing ? cnt : ((OFFW'(b) < off) ? row + 1'b1 : row);
      bank_we[b]  = clearing ||
                    (accept && req_store && !fault && (32'(lane_idx[b]) < nbytes));
      bank_wd[b]  = clearing ? 8'h00 :
                    8'(req_wdata >> (8 * (nbytes - 1 - int'(lane_idx[b]))));
    end
  end

  for (genvar b = 0; b < LANES; b++) begin : g_bank
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;
    always_ff @(posedge CLOCK_50) begin
      if (bank_we[b]) mem[bank_row[b]] <= bank_wd[b];
      rd_q <= mem[bank_row[b]];
    end
    assign bank_rd[b] = rd_q;
  end

  logic [OFFW-1:0] off_q;
  logic [2:0]      size_q;
  logic            signed_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      off_q     <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
    end else begin
      rsp_valid <= accept && (!req_store || fault);
      rsp_error <= accept && fault;
      if (accept) begin
        off_q    <= off;
        size_q   <= req_size;
        signed_q <= req_signed;
      end
    end
  end

  logic [8*LANES-1:0] load_dat;
  logic               sign_bit;
  int                 nq;

  assign nq = 32'd1 << size_q;

  always_comb begin
    load_dat = '0;
    sign_bit = bank_rd[off_q][7];
    for (int j = 0; j < LANES; j++) begin
      if (j < nq)
        load_dat[8*j +: 8] = bank_rd[off_q + OFFW'(nq - 1 - j)];
      else if (signed_q)
        load_dat[8*j +: 8] = {8{sign_bit}};
    end
    rsp_rdata = (rsp_valid && !rsp_error) ? load_dat : '0;
  end

endmodule

// File: tb/tb_banked_mem_unit.sv
// Bench for banked_mem_unit: a large no-clear instance and a small clearing, alignment-checked instance.
module tb_banked_mem_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_a, vld_a, rdy_a, st_a, sg_a, rv_a, re_a;
  logic [2:0]  sz_a;
  logic [17:0] addr_a;
  logic [31:0] wd_a, rd_a;

  logic        rst_b, vld_b, rdy_b, st_b, sg_b, rv_b, re_b;
  logic [2:0]  sz_b;
  logic [5:0]  addr_b;
  logic [31:0] wd_b, rd_b;

  banked_mem_unit #(.LANES(4), .ADDR_WIDTH(18), .ALLOW_MISALIGNED(1'b1), .CLEAR_ON_RESET(1'b0)) u_a (
    .CLOCK_50(clk), .reset(rst_a), .req_valid(vld_a), .req_ready(rdy_a), .req_store(st_a),
    .req_size(sz_a), .req_signed(sg_a), .req_addr(addr_a), .req_wdata(wd_a),
    .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_error(re_a));

  banked_mem_unit #(.LANES(4), .ADDR_WIDTH(6), .ALLOW_MISALIGNED(1'b0), .CLEAR_ON_RESET(1'b1)) u_b (
    .CLOCK_50(clk), .reset(rst_b), .req_valid(vld_b), .req_ready(rdy_b), .req_store(st_b),
    .req_size(sz_b), .req_signed(sg_b), .req_addr(addr_b), .req_wdata(wd_b),
    .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_error(re_b));

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  task automatic mon(input bit isb, input logic v, input logic e, input logic [31:0] d);
    exp_t  ex;
    int    qs;
    string nm;
    nm = isb ? "b" : "a";
    qs = isb ? q_b.size() : q_a.size();
    if (v) begin
      checks++;
      if (qs == 0) begin
        errors++;
        $display("FAIL %s unexpected_rsp: got err=%0b data=%h at cyc %0d, required no response", nm, e, d, cyc);
      end else begin
        if (isb) ex = q_b.pop_front();
        else     ex = q_a.pop_front();
        if (ex.cyc != cyc || e !== ex.err || d !== ex.dat) begin
          errors++;
          $display("FAIL %s rsp: got cyc=%0d err=%0b data=%h, required cyc=%0d err=%0b data=%h",
                   nm, cyc, e, d, ex.cyc, ex.err, ex.dat);
        end
      end
    end else begin
      checks++;
      if (e !== 1'b0 || d !== 32'h0) begin
        errors++;
        $display("FAIL %s idle_outputs: got err=%0b data=%h, required 0/0", nm, e, d);
      end
      if (qs > 0) begin
        ex = isb ? q_b[0] : q_a[0];
        if (ex.cyc <= cyc) begin
          checks++;
          errors++;
          $display("FAIL %s missing_rsp: no rsp_valid at cyc %0d, required err=%0b data=%h",
                   nm, ex.cyc, ex.err, ex.dat);
          if (isb) void'(q_b.pop_front());
          else     void'(q_a.pop_front());
        end
      end
    end
  endtask

  task automatic issue(input bit isb, input logic st, input logic [2:0] sz, input logic sg,
                       input logic [17:0] addr, input logic [31:0] wd,
                       input logic eerr, input logic [31:0] edat);
    @(negedge clk);
    checks++;
    if ((isb ? rdy_b : rdy_a) !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_at_issue: got %b, required 1", isb ? "b" : "a", isb ? rdy_b : rdy_a);
    end
    if (isb) begin
      vld_a = 1'b0;
      vld_b = 1'b1; st_b = st; sz_b = sz; sg_b = sg; addr_b = addr[5:0]; wd_b = wd;
      if (!st || eerr) q_b.push_back('{cyc + 1, eerr, edat});
    end else begin
      vld_b = 1'b0;
      vld_a = 1'b1; st_a = st; sz_a = sz; sg_a = sg; addr_a = addr; wd_a = wd;
      if (!st || eerr) q_a.push_back('{cyc + 1, eerr, edat});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    vld_a = 1'b0;
    vld_b = 1'b0;
  endtask

  // Counts ready-low negedges starting at the current negedge
  task automatic count_low(output int la, output int lb);
    la = 0;
    lb = 0;
    repeat (40) begin
      if (!rdy_a) la++;
      if (!rdy_b) lb++;
      @(negedge clk);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  initial begin
    int la, lb;
    rst_a = 1'b1; vld_a = 1'b0; st_a = 1'b0; sz_a = '0; sg_a = 1'b0; addr_a = '0; wd_a = '0;
    rst_b = 1'b1; vld_b = 1'b0; st_b = 1'b0; sz_b = '0; sg_b = 1'b0; addr_b = '0; wd_b = '0;
    fork
      begin
        while (!done) begin
          @(negedge clk);
          mon(1'b0, rv_a, re_a, rd_a);
          mon(1'b1, rv_b, re_b, rd_b);
        end
      end
      begin
        @(negedge clk);
        check_int("reset_ready_a", int'(rdy_a), 0);
        check_int("reset_ready_b", int'(rdy_b), 0);
        check_int("reset_valid_a", int'(rv_a), 0);
        check_int("reset_valid_b", int'(rv_b), 0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        count_low(la, lb);
        check_int("noclear_ready_delay_a", la, 1);
        check_int("clear_ready_delay_b", lb, 16);

        // Cleared memory reads as zero
        issue(1, 0, 2, 0, 18'h08, 0, 0, 32'h0);
        issue(1, 0, 2, 1, 18'h00, 0, 0, 32'h0);
        idle();

        // Reset in the middle of the clear restarts the full sweep
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        repeat (4) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        count_low(la, lb);
        check_int("midclear_restart_b", lb, 16);

        // Alignment and size faults on the strict instance
        issue(1, 1, 2, 0, 18'h10, 32'h12345678, 0, 32'h0);
        issue(1, 0, 2, 0, 18'h11, 0, 1, 32'h0);
        issue(1, 1, 2, 0, 18'h12, 32'hAABBCCDD, 1, 32'h0);
        issue(1, 0, 2, 0, 18'h10, 0, 0, 32'h12345678);
        issue(1, 0, 3, 0, 18'h10, 0, 1, 32'h0);
        issue(1, 0, 1, 0, 18'h13, 0, 1, 32'h0);
        issue(1, 0, 1, 1, 18'h12, 0, 0, 32'h00005678);
        issue(1, 0, 0, 1, 18'h11, 0, 0, 32'h00000034);
        issue(1, 0, 2, 1, 18'h30, 0, 0, 32'h0);
        idle();

        // Big-endian word, sign/zero extension
        issue(0, 1, 2, 0, 18'h100, 32'hDEADBEEF, 0, 0);
        issue(0, 0, 2, 0, 18'h100, 0, 0, 32'hDEADBEEF);
        issue(0, 0, 0, 0, 18'h101, 0, 0, 32'h000000AD);
        issue(0, 0, 0, 1, 18'h101, 0, 0, 32'hFFFFFFAD);
        issue(0, 0, 1, 1, 18'h102, 0, 0, 32'hFFFFBEEF);
        // Unaligned straddling store
        issue(0, 1, 2, 0, 18'h103, 32'h11223344, 0, 0);
        issue(0, 0, 1, 0, 18'h104, 0, 0, 32'h00002233);
        issue(0, 0, 0, 0, 18'h103, 0, 0, 32'h00000011);
        issue(0, 0, 0, 0, 18'h102, 0, 0, 32'h000000BE);
        // Address-space wrap
        issue(0, 1, 2, 0, 18'h3FFFE, 32'hCAFEF00D, 0, 0);
        issue(0, 0, 1, 0, 18'h00000, 0, 0, 32'h0000F00D);
        issue(0, 0, 1, 0, 18'h3FFFE, 0, 0, 32'h0000CAFE);
        issue(0, 0, 1, 1, 18'h3FFFF, 0, 0, 32'hFFFFFEF0);
        // Store then immediate load, oversize store faults and writes nothing
        issue(0, 1, 0, 0, 18'h20, 32'h0000007A, 0, 0);
        issue(0, 0, 0, 0, 18'h20, 0, 0, 32'h0000007A);
        issue(0, 1, 3, 0, 18'h100, 32'hFFFFFFFF, 1, 32'h0);
        // Back-to-back word loads
        issue(0, 0, 2, 0, 18'h100, 0, 0, 32'hDEADBE11);
        issue(0, 0, 2, 0, 18'h3FFFE, 0, 0, 32'hCAFEF00D);
        issue(0, 0, 2, 0, 18'h102, 0, 0, 32'hBE112233);
        idle();

        // Reset on the edge a load is presented: no response
        @(negedge clk);
        vld_a = 1'b1; st_a = 1'b0; sz_a = 3'd2; addr_a = 18'h100; rst_a = 1'b1;
        @(negedge clk);
        check_int("reset_drops_load_a", int'(rv_a), 0);
        vld_a = 1'b0; rst_a = 1'b0;
        count_low(la, lb);
        check_int("noclear_ready_again_a", la, 1);

        repeat (3) @(negedge clk);
        done = 1'b1;
      end
    join
    checks++;
    if (q_a.size() + q_b.size() != 0) begin
      errors++;
      $display("FAIL pending_rsp: got %0d outstanding, required 0", q_a.size() + q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/banked_mem_unit.md
# banked_mem_unit

Parametrised byte-banked data memory for the execute/memory pipeline stage. It supports:
- loads and stores of 1..LANES bytes at any byte address, including unaligned and wrap-around accesses;
- big-endian byte order;
- sign or zero extension on loads.

The unit holds LANES internal byte-wide synchronous banks and tracks the load's byte offset internally. It has a valid/ready request handshake with a registered one-cycle load response, and an optional post-reset memory-clear sequence.

## Interface
- LANES, 4: number of byte banks; power of 2, 2..64; data width is 8*LANES.
- ADDR_WIDTH, 18: byte-address width; total capacity 2^ADDR_WIDTH bytes.
- ALLOW_MISALIGNED, 1: 1 = accesses may straddle a LANES boundary; 0 = misaligned access faults.
- CLEAR_ON_RESET, 1: 1 = zero all memory after reset; 0 = contents undefined, ready immediately.
- Bank depth DEPTH = 2^(ADDR_WIDTH - log2(LANES)).

Ports:
- CLOCK_50  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  3  log2 of the access byte count (0 = byte .. log2(LANES) = full word).
- req_signed  in  1  load only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_WIDTH  byte address of the most-significant data byte.
- req_wdata  in  8*LANES  store data, right-aligned.
- rsp_valid  out  1  one-cycle pulse: load data or fault report.
- rsp_rdata  out  8*LANES  load data, right-aligned and extended.
- rsp_error  out  1  one-cycle pulse with rsp_valid: request faulted.

## Operation
- Accept: a request is taken on the edge where req_valid && req_ready.
- Byte mapping (big-endian):
  - For an access of n = 2^req_size bytes, data byte (n-1-i), i.e. bits [8(n-1-i)+7 : 8(n-1-i)], lives at byte address A_i = (req_addr + i) mod 2^ADDR_WIDTH.
  - Byte address A lives in bank (A mod LANES), row (A >> log2(LANES)).
  - Rows of banks below req_addr mod LANES therefore take row+1, wrapping from DEPTH-1 to 0.
- Store: writes exactly n bytes; all other bytes are untouched. Bank write enables and data are rotated by req_addr mod LANES.
- Load:
  - All banks are read at their computed rows.
  - The offset, size and signed flag are registered at acceptance.
  - The next cycle, the bank outputs are rotated back using the registered offset.
  - The n bytes are right-aligned, and the upper bits are filled with 0 (unsigned) or with bit 8n-1 (signed).
- Fault conditions:
  - req_size > log2(LANES);
  - ALLOW_MISALIGNED=0 and (req_addr mod n) != 0.
- A faulting request is accepted but writes nothing. It produces rsp_valid=1, rsp_error=1, rsp_rdata=0 for both loads and stores.
- A non-faulting store produces no response.
- FSM:
  - CLEAR: row counter cnt writes 0 to row cnt of every bank; cnt increments each cycle; after row DEPTH-1, go to READY.
  - READY: req_ready=1.
  - Reset enters CLEAR with cnt=0 (CLEAR_ON_RESET=1) or READY (CLEAR_ON_RESET=0).
  - req_valid is ignored in CLEAR.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_error=0, rsp_rdata=0, cnt=0.
- rsp_rdata is 0 whenever rsp_valid=0.
- CLEAR duration: req_ready rises exactly DEPTH edges after the last edge sampling reset=1.
- With CLEAR_ON_RESET=0, req_ready rises 1 edge after the last edge sampling reset=1.
- Reset asserted mid-CLEAR restarts at cnt=0.
- Reset asserted with a load in flight drops the response: rsp_valid=0 in the next cycle.
- Load latency: accepted at edge t, so rsp_valid=1 with data for exactly the cycle between edges t and t+1.
- Fault latency is identical to load latency.
- Throughput: one request per cycle in READY; back-to-back loads give consecutive rsp_valid cycles.
- Store then load to overlapping bytes on consecutive cycles: the load returns the stored data, because the write completes at the store's acceptance edge.
- Same-edge read/write to one bank cannot occur, since there is one request per cycle.

## Test plan
- CLEAR_ON_RESET=1, ADDR_WIDTH=6, LANES=4 (DEPTH=16):
  - Reset 1 cycle -> req_ready low for 16 cycles, then high.
  - Word load anywhere -> 0x00000000.
  - Reset at cycle 5 of the clear -> a full 16 further cycles of req_ready=0.
- Store word 0xDEADBEEF at 0x100:
  - Word load 0x100 -> 0xDEADBEEF.
  - Unsigned byte load 0x101 -> 0x000000AD.
  - Signed byte load 0x101 -> 0xFFFFFFAD.
  - Signed halfword load 0x102 -> 0xFFFFBEEF.
- Unaligned: store word 0x11223344 at 0x103:
  - Halfword load 0x104 -> 0x00002233.
  - Byte load 0x103 -> 0x00000011.
  - Byte load 0x102 -> 0x000000BE (untouched from the previous store).
- Wrap (ADDR_WIDTH=18): store word 0xCAFEF00D at 0x3FFFE:
  - Halfword load 0x00000 -> 0x0000F00D.
  - Halfword load 0x3FFFE -> 0x0000CAFE.
- ALLOW_MISALIGNED=0:
  - Word load 0x101 -> rsp_valid=1, rsp_error=1, rsp_rdata=0.
  - Word store 0x102 -> error pulse; a subsequent word load 0x100 is unchanged.
  - req_size=3 -> error.
- Pipelining:
  - Store byte 0x7A at 0x20, then a byte load 0x20 on the next cycle -> 0x0000007A.
  - Three back-to-back word loads -> three consecutive rsp_valid cycles with the correct data in order.
